// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, PC-select encoding and the privilege-preserving PC increment.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_JR,
    SEL_JMP,
    SEL_BR,
    SEL_IRQ,
    SEL_EXC,
    SEL_RST
  } pc_sel_t;

  // Carry out of bit 30 is dropped so sequential fetch never changes PC[31].
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder for the fetch stage.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic        reset_i,
  input  logic        exc_i,
  input  logic        stall_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        jump_i,
  input  logic [30:0] jump_target_i,
  input  logic        br_taken_i,
  input  logic [30:0] br_target_i,
  input  logic        imem_ovf_i,
  input  logic        irq_i,
  input  logic [31:0] pc_i,
  output pc_sel_t     sel_o,
  output logic [31:0] pc_next_o,
  output logic        fault_o
);

  always_comb begin
    sel_o     = SEL_SEQ;
    pc_next_o = pc_plus4(pc_i);
    fault_o   = 1'b0;
    if (reset_i) begin
      sel_o     = SEL_RST;
      pc_next_o = RESET_PC;
    end else if (exc_i) begin
      sel_o     = SEL_EXC;
      pc_next_o = EXC_VEC;
    end else if (stall_i) begin
      sel_o     = SEL_HOLD;
      pc_next_o = pc_i;
    end else if (jr_i) begin
      sel_o     = SEL_JR;
      pc_next_o = jr_target_i;
    end else if (jump_i) begin
      sel_o     = SEL_JMP;
      pc_next_o = {pc_i[31], jump_target_i};
    end else if (br_taken_i) begin
      sel_o     = SEL_BR;
      pc_next_o = {pc_i[31], br_target_i};
    end else if (imem_ovf_i) begin
      // Fetch overflow shares the exception vector; fault_o tells it apart.
      sel_o     = SEL_EXC;
      pc_next_o = EXC_VEC;
      fault_o   = 1'b1;
    end else if (irq_i && !pc_i[31]) begin
      sel_o     = SEL_IRQ;
      pc_next_o = IRQ_VEC;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, ROM address, IF/ID register and redirect arbitration.
module if_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [30:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ovf,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc,
  input  logic        irq,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        irq_ack,
  output logic [31:0] irq_epc,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;
  logic [31:0] epc_q, epc_d;
  logic        fault_q, fault_d;

  pc_sel_t     sel;
  logic [31:0] pc_next;
  logic        sel_fault;
  logic        bubble;

  // Branch/jump targets inherit PC[31], so their own MSBs are deliberately dropped.
  logic        unused_target_msbs;
  assign unused_target_msbs = ^{jump_target[31], br_target[31]};

  pc_next_sel u_pc_next_sel (
    .reset_i       (reset),
    .exc_i         (exc),
    .stall_i       (stall),
    .jr_i          (jr),
    .jr_target_i   (jr_target),
    .jump_i        (jump),
    .jump_target_i (jump_target[30:0]),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target[30:0]),
    .imem_ovf_i    (imem_ovf),
    .irq_i         (irq),
    .pc_i          (pc_q),
    .sel_o         (sel),
    .pc_next_o     (pc_next),
    .fault_o       (sel_fault)
  );

  assign bubble = (sel == SEL_EXC) || (sel == SEL_JR) || (sel == SEL_JMP) ||
                  (sel == SEL_BR)  || (sel == SEL_IRQ);

  always_comb begin
    pc_d    = pc_next;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    ack_d   = (sel == SEL_IRQ);
    fault_d = sel_fault;
    epc_d   = (sel == SEL_IRQ) ? pc_q : epc_q;
    if (sel != SEL_HOLD) begin
      pc4_d = pc_plus4(pc_q);
      if (bubble) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end else begin
        instr_d = imem_data;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      epc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      epc_q   <= epc_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr   = pc_q[30:0];
  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign irq_ack     = ack_q;
  assign irq_epc     = epc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reference model of the fetch rules plus directed literal checks.
module tb_if_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, imem_ovf, stall, br_taken, jump, jr, exc, irq;
  logic [31:0] br_target, jump_target, jr_target;
  logic [30:0] imem_addr;
  logic [31:0] imem_data, pc_out, if_id_instr, if_id_pc4, irq_epc;
  logic        if_id_valid, irq_ack, fetch_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [30:0] a);
    return {a, 1'b1} ^ 32'h5A5A_0000;
  endfunction

  assign imem_data = rom(imem_addr);

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_ovf    (imem_ovf),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .jr          (jr),
    .jr_target   (jr_target),
    .exc         (exc),
    .irq         (irq),
    .pc_out      (pc_out),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .irq_ack     (irq_ack),
    .irq_epc     (irq_epc),
    .fetch_fault (fetch_fault)
  );

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_ack, m_fault;

  function automatic logic [31:0] wrap4(input logic [31:0] p);
    logic [30:0] low;
    low = p[30:0] + 31'd4;
    return {p[31], low};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what each output must be after every clock edge.
  always @(posedge clk) begin : model
    logic [31:0] p;
    p = m_pc;
    if (reset) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_ack = 0; m_fault = 0; m_epc = 0;
    end else begin
      m_ack = 0;
      m_fault = 0;
      if (exc) begin
        m_pc = EXC_VEC; m_instr = 0; m_valid = 0; m_pc4 = wrap4(p);
      end else if (!stall) begin
        m_pc4 = wrap4(p);
        m_instr = 0;
        m_valid = 0;
        if (jr)                 m_pc = jr_target;
        else if (jump)          m_pc = {p[31], jump_target[30:0]};
        else if (br_taken)      m_pc = {p[31], br_target[30:0]};
        else if (imem_ovf)      begin m_pc = EXC_VEC; m_fault = 1; end
        else if (irq && !p[31]) begin m_pc = IRQ_VEC; m_ack = 1; m_epc = p; end
        else begin
          m_pc = wrap4(p); m_valid = 1; m_instr = rom(p[30:0]);
        end
      end
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("pc_out", pc_out, m_pc);
      chk("imem_addr", {1'b0, imem_addr}, {1'b0, m_pc[30:0]});
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc4", if_id_pc4, m_pc4);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("irq_ack", {31'b0, irq_ack}, {31'b0, m_ack});
      chk("irq_epc", irq_epc, m_epc);
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    reset = 1; imem_ovf = 0; stall = 0; br_taken = 0; jump = 0; jr = 0; exc = 0; irq = 0;
    br_target = 0; jump_target = 0; jr_target = 0;
    cyc(); cyc();
    chk("rst_pc", pc_out, 32'h8000_0000);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_epc", irq_epc, 32'h0);

    reset = 0; cyc();
    chk("seq1_pc", pc_out, 32'h8000_0004);
    chk("seq1_valid", {31'b0, if_id_valid}, 32'h1);
    chk("seq1_instr", if_id_instr, 32'h5A5A_0001);
    cyc();
    chk("seq2_pc", pc_out, 32'h8000_0008);
    chk("seq2_instr", if_id_instr, 32'h5A5A_0009);
    chk("seq2_pc4", if_id_pc4, 32'h8000_0008);

    jr = 1; jr_target = 32'h0000_0010; cyc(); jr = 0;
    chk("jr_pc", pc_out, 32'h0000_0010);
    chk("jr_bubble", {31'b0, if_id_valid}, 32'h0);
    jump = 1; jump_target = 32'h8000_0040; cyc(); jump = 0;
    chk("jmp_pc", pc_out, 32'h0000_0040);

    jr = 1; jr_target = 32'h0000_0020; cyc(); jr = 0;
    irq = 1; cyc();
    chk("irq_pc", pc_out, 32'h8000_0004);
    chk("irq_ack", {31'b0, irq_ack}, 32'h1);
    chk("irq_epc", irq_epc, 32'h0000_0020);
    cyc();
    chk("irq_masked_ack", {31'b0, irq_ack}, 32'h0);
    chk("irq_masked_pc", pc_out, 32'h8000_0008);
    irq = 0;

    stall = 1; br_taken = 1; br_target = 32'h0000_0100;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", pc_out, 32'h8000_0008);
      chk("stall_instr", if_id_instr, 32'h5A5A_0009);
    end
    stall = 0; cyc(); br_taken = 0;
    chk("br_pc", pc_out, 32'h8000_0100);
    chk("br_bubble", {31'b0, if_id_valid}, 32'h0);

    jr = 1; jr_target = 32'h0000_0030; cyc(); jr = 0;
    exc = 1; stall = 1; irq = 1; cyc(); exc = 0; stall = 0; irq = 0;
    chk("exc_pc", pc_out, 32'h8000_0008);
    chk("exc_valid", {31'b0, if_id_valid}, 32'h0);
    chk("exc_no_ack", {31'b0, irq_ack}, 32'h0);

    jr = 1; jr_target = 32'h0000_0280; cyc(); jr = 0;
    imem_ovf = 1; cyc(); imem_ovf = 0;
    chk("ovf_fault", {31'b0, fetch_fault}, 32'h1);
    chk("ovf_pc", pc_out, 32'h8000_0008);
    cyc();
    chk("ovf_pulse_end", {31'b0, fetch_fault}, 32'h0);

    jr = 1; jr_target = 32'h7FFF_FFFC; cyc(); jr = 0;
    cyc();
    chk("wrap_pc", pc_out, 32'h0000_0000);
    chk("wrap_pc4", if_id_pc4, 32'h0000_0000);
    chk("wrap_instr", if_id_instr, 32'hA5A5_FFF9);

    reset = 1; exc = 1; stall = 1; cyc(); reset = 0; exc = 0; stall = 0;
    chk("midrst_pc", pc_out, 32'h8000_0000);
    chk("midrst_valid", {31'b0, if_id_valid}, 32'h0);
    cyc();
    chk("midrst_seq", pc_out, 32'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS pipeline. Owns the program counter, drives the asynchronous instruction ROM with `PC[30:0]`, and registers the returned word into the IF/ID pipeline register. It arbitrates the next PC between sequential fetch, ID-stage branch/jump/jr redirects, the external interrupt vector and the exception vector. It also enforces the kernel bit `PC[31]`.

## Interface
- `RESET_PC`, `32'h8000_0000`: PC loaded on reset (kernel mode, ROM word 0).
- `IRQ_VEC`, `32'h8000_0004`: interrupt entry address.
- `EXC_VEC`, `32'h8000_0008`: exception entry address.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out 31: `PC[30:0]` to ROM, combinational from PC register.
- `imem_data` in 32: ROM word, valid the same cycle.
- `imem_ovf` in 1: ROM out-of-range flag for the current `imem_addr`.
- `stall` in 1: hazard unit holds PC and IF/ID.
- `br_taken` in 1, `br_target` in 32: ID-stage taken branch.
- `jump` in 1, `jump_target` in 32: ID-stage j/jal.
- `jr` in 1, `jr_target` in 32: ID-stage jr/jalr.
- `exc` in 1: exception raised by a later stage; also flushes IF/ID.
- `irq` in 1: level interrupt request from the timer/peripheral block.
- `pc_out` out 32: current PC.
- `if_id_instr` out 32, `if_id_pc4` out 32, `if_id_valid` out 1: IF/ID register.
- `irq_ack` out 1: one-cycle pulse in the cycle the interrupt redirect is taken.
- `irq_epc` out 32: PC of the squashed fetch, i.e. the return address. Valid with `irq_ack`.
- `fetch_fault` out 1: one-cycle pulse when `imem_ovf` redirects the fetch to `EXC_VEC`.

## Operation
- Next-PC priority, highest first:
  1. `reset` → `RESET_PC`.
  2. `exc` → `EXC_VEC`.
  3. `stall` → hold.
  4. `jr` → `jr_target` (all 32 bits; this is the only path that can clear `PC[31]`).
  5. `jump` → `{PC[31], jump_target[30:0]}`.
  6. `br_taken` → `{PC[31], br_target[30:0]}`.
  7. `imem_ovf` → `EXC_VEC` with `fetch_fault`.
  8. `irq` while `PC[31]==0` → `IRQ_VEC` with `irq_ack`.
  9. Otherwise `{PC[31], PC[30:0]+4}`. The carry out of bit 30 is dropped, so the add wraps inside the privilege region.
- At most one of `jr`, `jump` and `br_taken` is asserted per cycle; this is the decoder's guarantee. The stage applies the priority above regardless.
- IF/ID loads the following on every non-stalled cycle: `if_id_instr <= imem_data`, `if_id_pc4 <= PC+4` (same wrap rule), `if_id_valid <= 1`.
- A bubble is forced (`if_id_valid <= 0`, `if_id_instr <= 0`) on each of the following:
  - `exc`;
  - a jr/jump/branch redirect, which squashes the wrong-path fetch (there is no delay slot);
  - `imem_ovf`;
  - an interrupt redirect.
- `irq` is masked while `PC[31]==1`: kernel code, including handlers, is not interruptible. `irq` is also ignored in any cycle with stall, exc or a redirect; it is retried the next cycle.
- Interrupt: `irq_epc` is the PC of the instruction not issued, so that the handler's return `jr` re-executes it.
- Stall during a redirect request: the stall holds. The ID stage re-presents the redirect after the stall releases.

## Timing
- Reset values:
  - PC = `RESET_PC`;
  - `if_id_instr = 0`, `if_id_pc4 = 0`, `if_id_valid = 0`;
  - `irq_ack = 0`, `fetch_fault = 0`, `irq_epc = 0`.
- Combinational path: `imem_addr` → ROM → IF/ID. Fetch latency is one cycle from PC update to `if_id_instr`.
- `irq_ack` and `fetch_fault` are registered and assert in the cycle after the decision, aligned with the PC already equal to the vector.
- Reset asserted mid-stream overrides `exc` and `stall` in the same cycle. No pending state survives reset.

## Structure
- Shared package `mips_pkg`: `RESET_PC`, `IRQ_VEC`, `EXC_VEC`, the `NOP` word `32'h0`, and a `pc_sel_t` enum (`SEL_SEQ`, `SEL_HOLD`, `SEL_JR`, `SEL_JMP`, `SEL_BR`, `SEL_IRQ`, `SEL_EXC`, `SEL_RST`).
- One natural sub-module, `pc_next_sel`: pure combinational priority encoder producing `pc_sel_t` plus the next PC. The PC and IF/ID registers stay in `if_stage`.

## Test plan
- Reset release with a ROM model: PC goes 0x80000000 → 0x80000004 → 0x80000008. `if_id_instr` trails by one cycle; `if_id_valid` rises one cycle after reset drops.
- `jr` with `jr_target`=0x00000010 from kernel mode: PC becomes 0x00000010 with `PC[31]`=0 and one bubble. A following `jump_target`=0x8000_0040 yields PC 0x00000040, so the privilege bit is not raised.
- User PC 0x00000020 with `irq`=1: PC becomes 0x80000004, `irq_ack` pulses once, `irq_epc`=0x00000020. Holding `irq` high in kernel mode causes no further ack.
- `stall` held 3 cycles while `br_taken` is asserted: PC and IF/ID stay frozen. After release, PC takes `{PC[31], br_target[30:0]}` and one bubble follows.
- `exc` together with `stall` and `irq`: PC = 0x80000008 next cycle, `if_id_valid`=0, no `irq_ack`.
- PC 0x00000280 with `imem_ovf`=1: `fetch_fault` pulses and PC = 0x80000008. A separate case at PC 0x7FFFFFFC wraps sequentially to 0x00000000.
